// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO (mult, multu, div, divu, mthi, mtlo).
// Latency: WIDTH busy cycles after start, then one FIN cycle with done=1 and HI/LO updated.
// Backpressure: start is ignored while busy=1 (no queuing); the hazard unit stalls on busy.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // Per-operation context captured when the op is accepted
  typedef struct packed {
    logic             is_div;
    logic             neg_res;   // negate product / quotient at the end
    logic             neg_rem;   // negate remainder at the end
    logic             dz;        // divisor was zero
    logic [WIDTH-1:0] rs_raw;    // original dividend, returned as HI on divide-by-zero
    logic [WIDTH-1:0] opb;       // multiplicand magnitude or divisor magnitude
  } ctx_t;

  state_t            state, state_nxt;
  ctx_t              ctx;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic [WIDTH-1:0]  acc_hi, acc_lo, acc_hi_n, acc_lo_n;
  logic [WIDTH:0]    add_sum, sub_diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]  fin_hi, fin_lo;
  logic              accept, last;
  logic              sgn_op, rs_neg, rt_neg;
  logic [WIDTH-1:0]  rs_mag, rt_mag;

  assign accept  = start && (state != RUN);
  assign cnt_inc = cnt + 1'b1;
  assign last    = (cnt_inc == CNT_W'(WIDTH));

  // Operand magnitudes; op[0]=0 selects the signed variants
  assign sgn_op = ~op[0];
  assign rs_neg = sgn_op & rs[WIDTH-1];
  assign rt_neg = sgn_op & rt[WIDTH-1];
  assign rs_mag = rs_neg ? -rs : rs;
  assign rt_mag = rt_neg ? -rt : rt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a start in FIN chains straight into the next RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIN;
      FIN:     state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // One shift-add or restoring-divide step, plus sign fix-up of the final step
  always_comb begin
    add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, ctx.opb} : '0);
    sub_diff = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, ctx.opb};
    if (!ctx.is_div) begin
      acc_hi_n = add_sum[WIDTH:1];
      acc_lo_n = {add_sum[0], acc_lo[WIDTH-1:1]};
    end else if (!sub_diff[WIDTH]) begin
      acc_hi_n = sub_diff[WIDTH-1:0];
      acc_lo_n = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      acc_hi_n = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
      acc_lo_n = {acc_lo[WIDTH-2:0], 1'b0};
    end
    prod   = {acc_hi_n, acc_lo_n};
    prod_s = ctx.neg_res ? -prod : prod;
    if (!ctx.is_div) begin
      fin_hi = prod_s[2*WIDTH-1:WIDTH];
      fin_lo = prod_s[WIDTH-1:0];
    end else if (ctx.dz) begin
      fin_hi = ctx.rs_raw;
      fin_lo = '1;
    end else begin
      fin_hi = ctx.neg_rem ? -acc_hi_n : acc_hi_n;
      fin_lo = ctx.neg_res ? -acc_lo_n : acc_lo_n;
    end
  end

  // Working registers: capture operands on accept, iterate while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (accept) begin
      ctx.is_div  <= op[1];
      ctx.neg_res <= rs_neg ^ rt_neg;
      ctx.neg_rem <= rs_neg;
      ctx.dz      <= (rt == '0);
      ctx.rs_raw  <= rs;
      ctx.opb     <= op[1] ? rt_mag : rs_mag;
      acc_hi      <= '0;
      acc_lo      <= op[1] ? rs_mag : rt_mag;
      cnt         <= '0;
    end else if (state == RUN) begin
      acc_hi <= acc_hi_n;
      acc_lo <= acc_lo_n;
      cnt    <= last ? '0 : cnt_inc;
    end
  end

  // Architectural HI/LO and sticky divide-by-zero; only the final step or mthi/mtlo touch them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (state == RUN) begin
      if (last) begin
        hi <= fin_hi;
        lo <= fin_lo;
        if (ctx.is_div) div_zero <= ctx.dz;
      end
    end else if (!start) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/div_zero, a monitor pops on done.
// Directed vectors with hand-computed results, plus latency, back-to-back and reset checks.
// All waits are bounded; a global watchdog ends the run if something stalls.
module tb_muldiv_unit;

  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  logic        clk, rst_n, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] rs, rt, wdata, hi, lo;
  logic        busy, done, div_zero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, want no result", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_hi", hi, mon_e.hi);
        check("res_lo", lo, mon_e.lo);
        check("res_div_zero", {31'b0, div_zero}, {31'b0, mon_e.dz});
      end
    end
  end

  // Caller is at a negedge; start is held for exactly one rising edge, then operands scrambled
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    exp_q.push_back(exp_t'{hi: ehi, lo: elo, dz: edz});
    @(posedge clk);
    #1;
    start = 1'b0;
    rs    = $urandom;
    rt    = $urandom;
  endtask

  // Counts busy cycles; returns at the first negedge with busy low
  task automatic wait_done(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int c;
    @(negedge clk);
    issue(o, a, b, ehi, elo, edz);
    wait_done(c);
    check("busy_cycles", 32'(c), 32'd32);
    check("done_pulse", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; op = 2'd0; rs = '0; rt = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_div_zero", {31'b0, div_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;

    // Basic arithmetic vectors
    run(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run(MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run(DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);
    run(DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1);
    run(DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0);

    // Write in the start cycle is dropped; stray start and mthi while busy are ignored
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h0000DEAD;
    issue(MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    hi_we = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = DIVU; rs = 32'd1; rt = 32'd1;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b1;
    wdata = 32'h00001234;
    @(negedge clk);
    hi_we = 1'b0;
    wait_done(n);
    check("busy_cycles_mid", 32'(n), 32'd26);
    check("done_pulse_mid", {31'b0, done}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("hi_write_dropped", hi, 32'd0);
    hi_we = 1'b1;
    wdata = 32'h00001234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h00001234);
    check("mthi_lo_kept", lo, 32'd42);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthilo_hi", hi, 32'hA5A5A5A5);
    check("mthilo_lo", lo, 32'hA5A5A5A5);

    // Reset in the middle of a divide discards it
    start = 1'b1; op = DIV; rs = 32'd1000; rt = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_rst", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

    // Signed overflow, then start held through FIN chains the next op with no idle cycle
    @(negedge clk);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    wait_done(n);
    check("busy_cycles_ovf", 32'(n), 32'd32);
    check("done_pulse_ovf", {31'b0, done}, 32'd1);
    issue(MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0);
    check("b2b_no_idle", {31'b0, busy}, 32'd1);
    wait_done(n);
    check("busy_cycles_b2b", 32'(n), 32'd32);

    // Sticky div_zero survives a following multiply
    run(DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
    run(MULTU, 32'd3, 32'd5, 32'd0, 32'd15,       1'b1);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
